inst_loader: RTL and testbench

- Writer side of the instruction memory's load port.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Drives one write strobe per word, with addresses stepping through the instruction space from the start address.
- Holds the core in reset until the program image is resident.

---
 rtl/inst_loader.sv | 173 +++++++++++++++++
 tb/tb_inst_loader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_loader.sv
// Byte-stream writer for the instruction memory load port: packs little-endian words,
// strobes them to consecutive addresses and holds the core in reset meanwhile.
// Optional macro LOADER_CHECKSUM_EN appends a trailing 8-bit sum byte that is verified before done.
module inst_loader #(
    parameter logic [31:0] START_ADDR = 32'h0000_0000,
    parameter int unsigned SPACE      = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] len,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [31:0] addr,
    output logic [31:0] load_inst,
    output logic        load,
    output logic        core_hold,
    output logic        done,
    output logic        err
);
    localparam int unsigned MAX_WORDS = SPACE / 4;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FILL  = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_CSUM  = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [15:0] word_idx_q, word_idx_d;
    logic [15:0] len_q, len_d;
    logic [31:0] asm_q, asm_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] load_inst_q, load_inst_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
    logic        fail_q, fail_d;
`endif

    logic accept;
    assign accept = byte_valid && byte_ready;

    always_comb begin
        state_d     = state_q;
        byte_idx_d  = byte_idx_q;
        word_idx_d  = word_idx_q;
        len_d       = len_q;
        asm_d       = asm_q;
        addr_d      = addr_q;
        load_inst_d = load_inst_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        csum_d      = csum_q;
        fail_d      = fail_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len == 16'd0) begin
                        done_d = 1'b1;
                    end else if ({16'd0, len} > MAX_WORDS) begin
                        err_d = 1'b1;
                    end else begin
                        len_d      = len;
                        word_idx_d = 16'd0;
                        byte_idx_d = 2'd0;
                        asm_d      = 32'd0;
`ifdef LOADER_CHECKSUM_EN
                        csum_d     = 8'd0;
`endif
                        state_d    = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                if (accept) begin
                    asm_d[8*byte_idx_q +: 8] = byte_in;
                    byte_idx_d = byte_idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    csum_d = csum_q + byte_in;
`endif
                    // Latch the write beat here so addr/load_inst hold between strobes.
                    if (byte_idx_q == 2'd3) begin
                        addr_d      = START_ADDR + {14'd0, word_idx_q, 2'b00};
                        load_inst_d = {byte_in, asm_q[23:0]};
                        state_d     = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                word_idx_d = word_idx_q + 16'd1;
                if ((word_idx_q + 16'd1) == len_q) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = ST_CSUM;
`else
                    state_d = ST_DONE;
                    done_d  = 1'b1;
`endif
                end else begin
                    state_d = ST_FILL;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (accept) begin
                    if (byte_in == csum_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        fail_d  = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                        fail_d  = 1'b1;
                    end
                end
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            byte_idx_q  <= 2'd0;
            word_idx_q  <= 16'd0;
            len_q       <= 16'd0;
            asm_q       <= 32'd0;
            addr_q      <= 32'd0;
            load_inst_q <= 32'd0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q      <= 8'd0;
            fail_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            byte_idx_q  <= byte_idx_d;
            word_idx_q  <= word_idx_d;
            len_q       <= len_d;
            asm_q       <= asm_d;
            addr_q      <= addr_d;
            load_inst_q <= load_inst_d;
            done_q      <= done_d;
            err_q       <= err_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q      <= csum_d;
            fail_q      <= fail_d;
`endif
        end
    end

    assign byte_ready = (state_q == ST_FILL) || (state_q == ST_CSUM);
    assign load       = (state_q == ST_WRITE);
    assign addr       = addr_q;
    assign load_inst  = load_inst_q;
    assign done       = done_q;
    assign err        = err_q;
`ifdef LOADER_CHECKSUM_EN
    // A failed checksum keeps the core parked until a good image lands.
    assign core_hold  = (state_q == ST_FILL) || (state_q == ST_WRITE) ||
                        (state_q == ST_CSUM) || fail_q;
`else
    assign core_hold  = (state_q == ST_FILL) || (state_q == ST_WRITE);
`endif
endmodule

// File: tb/tb_inst_loader.sv
// Scoreboard bench for inst_loader: expected writes are queued as bytes are driven
// and popped when the load strobe appears; build with LOADER_CHECKSUM_EN for the sum byte path.
module tb_inst_loader;
    localparam logic [31:0] START = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] len = 16'd0;
    logic [7:0]  byte_in = 8'd0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic [31:0] addr;
    logic [31:0] load_inst;
    logic        load;
    logic        core_hold;
    logic        done;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] sb_addr[$];
    logic [31:0] sb_data[$];
    logic [31:0] pay[$];
    logic [7:0]  sum;

    inst_loader #(.START_ADDR(START), .SPACE(4096)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .addr(addr), .load_inst(load_inst), .load(load),
        .core_hold(core_hold), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest queued write.
    always @(negedge clk) begin
        if (rst_n && load) begin
            if (sb_addr.size() == 0) begin
                check("load_unexpected", 32'd1, 32'd0);
            end else begin
                logic [31:0] ea, ed;
                ea = sb_addr.pop_front();
                ed = sb_data.pop_front();
                check("wr_addr", addr, ea);
                check("wr_data", load_inst, ed);
                check("ready_in_write", {31'd0, byte_ready}, 32'd0);
                check("hold_in_write", {31'd0, core_hold}, 32'd1);
                $display("[TB] write addr=0x%08h data=0x%08h", addr, load_inst);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int k;
        k = 0;
        byte_in = b;
        byte_valid = 1'b1;
        sum = sum + b;
        while (!byte_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) check("ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        if (gap) begin
            byte_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
    endtask

    task automatic do_start(input logic [15:0] l);
        start = 1'b1;
        len = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!done && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("done_pulse", {31'd0, done}, 32'd1);
        check("hold_at_done", {31'd0, core_hold}, 32'd0);
        check("sb_drained", sb_addr.size(), 32'd0);
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    task automatic send_csum(input logic [7:0] c);
`ifdef LOADER_CHECKSUM_EN
        send_byte(c, 1'b0);
`endif
        byte_valid = 1'b0;
    endtask

    // Full load of the words in pay; gap_mode 0=valid held, 1=toggled, 2=random.
    task automatic run_load(input int gap_mode);
        logic [7:0] s;
        for (int i = 0; i < pay.size(); i++) begin
            sb_addr.push_back(START + 32'(4 * i));
            sb_data.push_back(pay[i]);
        end
        sum = 8'd0;
        do_start(16'(pay.size()));
        check("hold_after_start", {31'd0, core_hold}, 32'd1);
        for (int i = 0; i < pay.size(); i++) begin
            for (int j = 0; j < 4; j++) begin
                bit g;
                g = (gap_mode == 1) ? 1'b1 : (gap_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
                send_byte(pay[i][8*j +: 8], g);
            end
        end
        s = sum;
        send_csum(s);
        wait_done();
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_ready", {31'd0, byte_ready}, 32'd0);
        check("rst_load", {31'd0, load}, 32'd0);
        check("rst_hold", {31'd0, core_hold}, 32'd0);
        check("rst_done_err", {30'd0, done, err}, 32'd0);
        check("rst_addr", addr, 32'd0);
        check("rst_inst", load_inst, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Two-word load, valid held high
        pay = '{32'h0000_0013, 32'h0010_0093};
        run_load(0);
        // Same load, valid toggling
        run_load(1);

        // len=0 completes immediately without touching memory
        do_start(16'd0);
        check("len0_done", {31'd0, done}, 32'd1);
        check("len0_hold", {31'd0, core_hold}, 32'd0);
        check("len0_ready", {31'd0, byte_ready}, 32'd0);
        @(negedge clk);
        check("len0_pulse_end", {31'd0, done}, 32'd0);

        // Over-length request is rejected
        do_start(16'd1025);
        check("big_err", {31'd0, err}, 32'd1);
        check("big_done", {31'd0, done}, 32'd0);
        check("big_hold", {31'd0, core_hold}, 32'd0);
        @(negedge clk);
        check("big_pulse_end", {31'd0, err}, 32'd0);
        check("big_ready", {31'd0, byte_ready}, 32'd0);

        // Maximum length is accepted (abort by reset after entering FILL)
        do_start(16'd1024);
        check("max_accept", {31'd0, byte_ready}, 32'd1);

        // Reset in the middle of a word drops the partial word
        sum = 8'd0;
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        byte_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ready", {31'd0, byte_ready}, 32'd0);
        check("midrst_hold", {31'd0, core_hold}, 32'd0);
        check("midrst_outs", {29'd0, load, done, err}, 32'd0);
        check("midrst_addr", addr, 32'd0);
        check("midrst_inst", load_inst, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pay = '{32'hDDCC_BBAA};
        run_load(0);

        // Start during FILL is ignored
        pay = '{32'h1122_3344, 32'h5566_7788};
        sb_addr.push_back(START);        sb_data.push_back(pay[0]);
        sb_addr.push_back(START + 32'd4); sb_data.push_back(pay[1]);
        sum = 8'd0;
        do_start(16'd2);
        send_byte(8'h44, 1'b0);
        send_byte(8'h33, 1'b1);
        do_start(16'd5);
        check("restart_ignored", {31'd0, byte_ready}, 32'd1);
        send_byte(8'h22, 1'b0);
        send_byte(8'h11, 1'b0);
        send_word(pay[1], 1'b0);
        send_csum(sum);
        wait_done();
        repeat (6) @(negedge clk);
        check("idle_after", {30'd0, byte_ready, core_hold}, 32'd0);

        // Longer load with random gaps
        pay = {};
        for (int i = 0; i < 5; i++) pay.push_back($urandom);
        run_load(2);

`ifdef LOADER_CHECKSUM_EN
        // Good checksum, then bad checksum
        pay = '{32'h0403_0201};
        run_load(0);
        sb_addr.push_back(START); sb_data.push_back(32'h0403_0201);
        sum = 8'd0;
        do_start(16'd1);
        send_word(32'h0403_0201, 1'b0);
        send_byte(8'h0B, 1'b0);
        byte_valid = 1'b0;
        begin
            int k;
            k = 0;
            while (!err && !done && k < 50) begin
                @(negedge clk);
                k++;
            end
        end
        check("csum_err", {31'd0, err}, 32'd1);
        check("csum_nodone", {31'd0, done}, 32'd0);
        repeat (3) @(negedge clk);
        check("csum_hold", {31'd0, core_hold}, 32'd1);
        check("csum_ready", {31'd0, byte_ready}, 32'd0);
        pay = '{32'hCAFE_F00D};
        run_load(0);
        repeat (2) @(negedge clk);
        check("csum_hold_cleared", {31'd0, core_hold}, 32'd0);
`endif

        repeat (3) @(negedge clk);
        check("sb_final", sb_addr.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
